// File: rtl/i2c_slave_regs.sv
// I2C target holding a small byte register bank, with write events and a host read port.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample stability filter after the SCL/SDA synchronisers.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int          NUM_REGS   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i2c_scl,
    inout  wire                         i2c_sda,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  wr_data,
    input  logic [$clog2(NUM_REGS)-1:0] host_addr,
    output logic [7:0]                  host_data,
    output logic                        busy
);
    localparam int PTR_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_RX_BYTE, S_RX_ACK, S_TX_BYTE, S_TX_ACK, S_WAIT_STOP
    } state_t;

    logic [1:0] r_scl_sync, r_sda_sync;
    logic       w_scl, w_sda;
    logic       r_scl_prev, r_sda_prev;
    logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [6:0]       r_shift, w_shift_nxt;
    logic [PTR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
    logic             r_rw, w_rw_nxt;
    logic             r_phase, w_phase_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_sda_oe, w_sda_oe_nxt;
    logic             w_we;
    logic [7:0]       w_rx_byte;
    logic [7:0]       r_regs [NUM_REGS];
    logic             r_wr_strobe;
    logic [PTR_W-1:0] r_wr_addr;
    logic [7:0]       r_wr_data;

    // Bus lines idle high, so the synchronisers reset to 1 to avoid a spurious edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl};
            r_sda_sync <= {r_sda_sync[0], i2c_sda};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist, r_sda_hist;
    logic       r_scl_held, r_sda_held;

    // Filtered level follows the synced input only once three consecutive samples agree.
    assign w_scl = ((r_scl_sync[1] == r_scl_hist[0]) && (r_scl_hist[0] == r_scl_hist[1]))
                   ? r_scl_sync[1] : r_scl_held;
    assign w_sda = ((r_sda_sync[1] == r_sda_hist[0]) && (r_sda_hist[0] == r_sda_hist[1]))
                   ? r_sda_sync[1] : r_sda_held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_held <= 1'b1;
            r_sda_held <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
            r_scl_held <= w_scl;
            r_sda_held <= w_sda;
        end
    end
`else
    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_sda_rise = w_sda & ~r_sda_prev;
    assign w_sda_fall = ~w_sda & r_sda_prev;
    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;
    assign w_rx_byte  = {r_shift, w_sda};
    assign w_ptr_inc  = r_ptr + PTR_W'(1);

    // START clears busy so a repeated START to another address leaves us unaddressed.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_phase_nxt   = r_phase;
        w_busy_nxt    = r_busy;
        w_sda_oe_nxt  = r_sda_oe;
        w_we          = 1'b0;
        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 3'd7;
            w_ptr_nxt     = '0;
            w_sda_oe_nxt  = 1'b0;
            w_busy_nxt    = 1'b0;
            w_phase_nxt   = 1'b0;
        end else if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: if (w_scl_rise) begin
                    w_shift_nxt = w_rx_byte[6:0];
                    if (r_bit_cnt == 3'd0) begin
                        if (r_shift == SLAVE_ADDR) begin
                            w_rw_nxt    = w_sda;
                            w_busy_nxt  = 1'b1;
                            w_phase_nxt = 1'b0;
                            w_state_nxt = S_ADDR_ACK;
                        end else begin
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                S_ADDR_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_oe_nxt = 1'b1;
                        w_phase_nxt  = 1'b1;
                    end else if (!r_rw) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 3'd7;
                        w_state_nxt   = S_RX_BYTE;
                    end else begin
                        w_shift_nxt   = r_regs[r_ptr][6:0];
                        w_sda_oe_nxt  = ~r_regs[r_ptr][7];
                        w_bit_cnt_nxt = 3'd7;
                        w_state_nxt   = S_TX_BYTE;
                    end
                end
                S_RX_BYTE: if (w_scl_rise) begin
                    w_shift_nxt = w_rx_byte[6:0];
                    if (r_bit_cnt == 3'd0) begin
                        w_we        = 1'b1;
                        w_ptr_nxt   = w_ptr_inc;
                        w_phase_nxt = 1'b0;
                        w_state_nxt = S_RX_ACK;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                S_RX_ACK: if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_oe_nxt = 1'b1;
                        w_phase_nxt  = 1'b1;
                    end else begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 3'd7;
                        w_state_nxt   = S_RX_BYTE;
                    end
                end
                S_TX_BYTE: if (w_scl_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        w_sda_oe_nxt = 1'b0;
                        w_phase_nxt  = 1'b0;
                        w_state_nxt  = S_TX_ACK;
                    end else begin
                        w_sda_oe_nxt  = ~r_shift[6];
                        w_shift_nxt   = {r_shift[5:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                    end
                end
                S_TX_ACK: begin
                    if (!r_phase && w_scl_rise) begin
                        w_ptr_nxt = w_ptr_inc;
                        if (!w_sda) begin
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_WAIT_STOP;
                        end
                    end else if (r_phase && w_scl_fall) begin
                        w_shift_nxt   = r_regs[r_ptr][6:0];
                        w_sda_oe_nxt  = ~r_regs[r_ptr][7];
                        w_bit_cnt_nxt = 3'd7;
                        w_phase_nxt   = 1'b0;
                        w_state_nxt   = S_TX_BYTE;
                    end
                end
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd7;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_phase   <= 1'b0;
            r_busy    <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_rw      <= w_rw_nxt;
            r_phase   <= w_phase_nxt;
            r_busy    <= w_busy_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= w_we;
            if (w_we) begin
                r_regs[r_ptr] <= w_rx_byte;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_rx_byte;
            end
        end
    end

    assign i2c_sda   = r_sda_oe ? 1'b0 : 1'bz;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign host_data = r_regs[host_addr];
    assign busy      = r_busy;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged bus master plus a register-bank/write-event model.
// Glitch-rejection frames run only when I2C_GLITCH_FILTER_EN is defined.
module tb_i2c_slave_regs;
    localparam logic [6:0] SLAVE_ADDR = 7'h50;
    localparam int NUM_REGS = 4;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclDrv = 1'b1;
    logic       mSdaLow = 1'b0;
    logic [1:0] host_addr = 2'd0;
    wire        sdaBus;
    logic       wr_strobe;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] host_data;
    logic       busy;

    pullup (sdaBus);
    assign sdaBus = mSdaLow ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regs #(.SLAVE_ADDR(SLAVE_ADDR), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst), .i2c_scl(sclDrv), .i2c_sda(sdaBus),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .host_addr(host_addr), .host_data(host_data), .busy(busy)
    );

    int         vecCount = 0;
    int         errCount = 0;
    int         strobeCount = 0;
    logic [7:0] modelRegs [NUM_REGS];
    logic [1:0] modelPtr = 2'd0;
    bit         modelAddressed = 1'b0;
    bit         modelRead = 1'b0;
    bit         chkReleased = 1'b0;
    bit         prevStrobe = 1'b0;
    logic [1:0] expAddrQ [$];
    logic [7:0] expDataQ [$];
    logic [1:0] strobeLog [$];

    function automatic logic sdaLevel();
        return (sdaBus === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every write event must match the model's queue, and host_data must track the bank.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_strobe) begin
                strobeCount++;
                strobeLog.push_back(wr_addr);
                checkOutput("strobe gap", {31'd0, prevStrobe}, 32'd0);
                if (expAddrQ.size() == 0) begin
                    checkOutput("unexpected wr_strobe", 32'd1, 32'd0);
                end else begin
                    logic [1:0] a;
                    logic [7:0] d;
                    a = expAddrQ.pop_front();
                    d = expDataQ.pop_front();
                    checkOutput("wr_addr", {30'd0, wr_addr}, {30'd0, a});
                    checkOutput("wr_data", {24'd0, wr_data}, {24'd0, d});
                    modelRegs[a] = d;
                end
            end
            prevStrobe = wr_strobe;
            checkOutput("host_data", {24'd0, host_data}, {24'd0, modelRegs[host_addr]});
            if (chkReleased && !mSdaLow) checkOutput("sda released", {31'd0, sdaLevel()}, 32'd1);
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_REGS; i++) modelRegs[i] = 8'h00;
        modelPtr = 2'd0;
        modelAddressed = 1'b0;
        expAddrQ.delete();
        expDataQ.delete();
    endtask

    task automatic applyStimulus(input logic bitVal, output logic sampled);
        mSdaLow = !bitVal;
        waitClk(Q);
        sclDrv = 1'b1;
        waitClk(Q);
        sampled = sdaLevel();
        waitClk(Q);
        sclDrv = 1'b0;
        waitClk(Q);
    endtask

    // Same bit timing, with a one-clock opposite-level SDA pulse while SCL is high.
    task automatic glitchBit(input logic bitVal);
        mSdaLow = !bitVal;
        waitClk(Q);
        sclDrv = 1'b1;
        waitClk(Q);
        mSdaLow = bitVal;
        waitClk(1);
        mSdaLow = !bitVal;
        waitClk(Q - 1);
        sclDrv = 1'b0;
        waitClk(Q);
    endtask

    task automatic i2cStart();
        mSdaLow = 1'b1;
        waitClk(Q);
        sclDrv = 1'b0;
        waitClk(Q);
        modelPtr = 2'd0;
        modelAddressed = 1'b0;
    endtask

    task automatic repStart();
        mSdaLow = 1'b0;
        waitClk(Q);
        sclDrv = 1'b1;
        waitClk(Q);
        mSdaLow = 1'b1;
        waitClk(Q);
        sclDrv = 1'b0;
        waitClk(Q);
        modelPtr = 2'd0;
        modelAddressed = 1'b0;
    endtask

    task automatic i2cStop();
        mSdaLow = 1'b1;
        waitClk(Q);
        sclDrv = 1'b1;
        waitClk(Q);
        mSdaLow = 1'b0;
        waitClk(Q);
        modelAddressed = 1'b0;
        checkOutput("busy after stop", {31'd0, busy}, 32'd0);
    endtask

    task automatic sendByte(input logic [7:0] b, input bit isAddr, input bit glitch);
        logic s;
        bit expAck;
        expAck = isAddr ? (b[7:1] == SLAVE_ADDR) : (modelAddressed && !modelRead);
        if (!isAddr && expAck) begin
            expAddrQ.push_back(modelPtr);
            expDataQ.push_back(b);
            modelPtr = 2'((int'(modelPtr) + 1) % NUM_REGS);
        end
        for (int i = 7; i >= 0; i--) begin
            if (glitch) glitchBit(b[i]);
            else applyStimulus(b[i], s);
        end
        applyStimulus(1'b1, s);
        checkOutput(isAddr ? "addr ack" : "data ack", {31'd0, s}, expAck ? 32'd0 : 32'd1);
        if (isAddr) begin
            modelAddressed = expAck;
            modelRead = b[0];
            checkOutput("busy after addr", {31'd0, busy}, {31'd0, expAck});
        end
    endtask

    task automatic readByte(input bit ackIt, output logic [7:0] got);
        logic s;
        logic [7:0] exp;
        exp = modelRegs[modelPtr];
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(1'b1, s);
            got[i] = s;
        end
        checkOutput("read byte", {24'd0, got}, {24'd0, exp});
        applyStimulus(ackIt ? 1'b0 : 1'b1, s);
        modelPtr = 2'((int'(modelPtr) + 1) % NUM_REGS);
        if (!ackIt) modelAddressed = 1'b0;
    endtask

    task automatic checkBank(input logic [31:0] lits);
        @(negedge clk);
        for (int i = 0; i < NUM_REGS; i++) begin
            #2 host_addr = 2'(i);
            #1 checkOutput($sformatf("bank[%0d]", i), {24'd0, host_data}, {24'd0, lits[8*i +: 8]});
        end
    endtask

    initial begin
        logic [7:0] got;
        int         mark;
        clearModel();
        waitClk(4);
        rst = 1'b0;
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset wr_strobe", {31'd0, wr_strobe}, 32'd0);
        checkOutput("reset wr_addr", {30'd0, wr_addr}, 32'd0);
        checkOutput("reset wr_data", {24'd0, wr_data}, 32'd0);
        checkOutput("reset sda", {31'd0, sdaLevel()}, 32'd1);
        checkBank(32'h0000_0000);
        waitClk(Q);

        i2cStart(); sendByte(8'hA0, 1, 0); sendByte(8'h5A, 0, 0); sendByte(8'hFF, 0, 0); i2cStop();

        mark = strobeCount;
        i2cStart(); sendByte(8'hA0, 1, 0); sendByte(8'hA5, 0, 0); i2cStop();
        checkOutput("write strobes", strobeCount - mark, 32'd1);
        checkOutput("write wr_addr", {30'd0, wr_addr}, 32'd0);
        checkOutput("write wr_data", {24'd0, wr_data}, 32'hA5);
        checkBank(32'h0000_FFA5);

        i2cStart(); sendByte(8'hA1, 1, 0); readByte(1, got);
        checkOutput("readback literal", {24'd0, got}, 32'hA5);
        checkOutput("busy before stop", {31'd0, busy}, 32'd1);
        i2cStop();

        mark = strobeCount;
        chkReleased = 1'b1;
        i2cStart(); sendByte(8'hA2, 1, 0); sendByte(8'h12, 0, 0); i2cStop();
        chkReleased = 1'b0;
        checkOutput("wrong addr strobes", strobeCount - mark, 32'd0);
        i2cStart(); sendByte(8'hA0, 1, 0); i2cStop();

        mark = strobeLog.size();
        i2cStart(); sendByte(8'hA0, 1, 0);
        sendByte(8'h11, 0, 0); sendByte(8'h22, 0, 0); sendByte(8'h33, 0, 0);
        sendByte(8'h44, 0, 0); sendByte(8'h55, 0, 0);
        i2cStop();
        checkOutput("burst strobes", strobeLog.size() - mark, 32'd5);
        for (int i = 0; i < 5; i++)
            if (mark + i < strobeLog.size())
                checkOutput($sformatf("burst addr %0d", i), {30'd0, strobeLog[mark + i]}, (i == 4) ? 32'd0 : i);
        checkBank(32'h4433_2255);

        mark = strobeCount;
        i2cStart(); sendByte(8'hA0, 1, 0);
        begin
            logic s;
            logic [7:0] partial;
            partial = 8'hC3;
            for (int i = 7; i >= 4; i--) applyStimulus(partial[i], s);
        end
        repStart(); sendByte(8'hA1, 1, 0); readByte(0, got);
        checkOutput("rep start literal", {24'd0, got}, 32'h55);
        checkOutput("busy after nack", {31'd0, busy}, 32'd0);
        chkReleased = 1'b1;
        waitClk(4 * Q);
        chkReleased = 1'b0;
        i2cStop();
        checkOutput("rep start strobes", strobeCount - mark, 32'd0);

`ifdef I2C_GLITCH_FILTER_EN
        mark = strobeCount;
        i2cStart(); sendByte(8'hA0, 1, 0); sendByte(8'h3C, 0, 1); i2cStop();
        checkOutput("glitch strobes", strobeCount - mark, 32'd1);
        i2cStart(); sendByte(8'hA1, 1, 0); readByte(0, got); i2cStop();
        checkOutput("glitch literal", {24'd0, got}, 32'h3C);
`endif

        i2cStart();
        begin
            logic s;
            logic [7:0] addrByte;
            addrByte = 8'hA0;
            for (int i = 7; i >= 0; i--) applyStimulus(addrByte[i], s);
        end
        mSdaLow = 1'b0;
        waitClk(Q);
        sclDrv = 1'b1;
        waitClk(Q / 2);
        checkOutput("ack driven", {31'd0, sdaLevel()}, 32'd0);
        #3 rst = 1'b1;
        #1;
        checkOutput("sda after rst", {31'd0, sdaLevel()}, 32'd1);
        checkOutput("busy after rst", {31'd0, busy}, 32'd0);
        clearModel();
        checkBank(32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        waitClk(2);
        sclDrv = 1'b0;
        waitClk(Q);
        i2cStop();
        i2cStart(); sendByte(8'hA0, 1, 0); i2cStop();

        checkOutput("pending writes", expAddrQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
